// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared defaults, FSM states and response record for data_mem_ctrl.
package data_mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_INIT_INDEX = 1;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic err;
  } rsp_t;
endpackage

// File: rtl/data_mem_rsp_fifo.sv
// data_mem_rsp_fifo: circular response FIFO; head is held stable until popped.
module data_mem_rsp_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push, pop;
  assign in_ready = cnt_q < CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign out_data = out_valid ? mem[rd_q] : '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word memory with self-fill after reset, byte-lane writes and
// fixed-latency in-order responses staged through a bounded FIFO.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int INIT_INDEX = DEF_INIT_INDEX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);
  localparam int NB = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int FW = IW + 1;
  localparam int OW = $clog2(RD_LAT + 2);
  localparam int RW = DATA_W + 1;
  state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic init_done_d;
  logic [OW-1:0] out_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word;
  logic [IW-1:0] idx, wr_idx;
  logic in_range, accept, pop, wr_en, fifo_ready, push_v;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic [RW-1:0] s0, push_d, fifo_out;
  assign word = req_addr >> OFF;
  assign idx = word[IW-1:0];
  assign in_range = 32'(word) < DEPTH;
  assign req_ready = init_done && state_q == RUN && out_q < OW'(RD_LAT + 1) && fifo_ready;
  assign accept = req_valid && req_ready;
  assign pop = rsp_valid && rsp_ready;
  always_comb begin
    fill_d = state_q == INIT ? fill_q + 1'b1 : fill_q;
    state_d = (state_q == INIT && fill_q == FW'(DEPTH - 1)) ? RUN : state_q;
    init_done_d = state_q == RUN;
  end
  // The fill and accepted writes share the single write port; INIT never accepts.
  always_comb begin
    wr_en = state_q == INIT || (accept && req_we && in_range);
    wr_idx = state_q == INIT ? fill_q[IW-1:0] : idx;
    wr_data = state_q == INIT ? (INIT_INDEX != 0 ? DATA_W'(fill_q[IW-1:0]) : '0) : req_wdata;
    wr_be = state_q == INIT ? '1 : req_be;
  end
  always_ff @(posedge clk)
    if (wr_en)
      for (int k = 0; k < NB; k++)
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
  assign s0 = {(accept && !req_we && in_range) ? mem[idx] : '0, !in_range};
  if (RD_LAT == 1) begin : g_direct
    assign push_v = accept;
    assign push_d = s0;
  end else begin : g_pipe
    logic pv [RD_LAT-1];
    logic [RW-1:0] pd [RD_LAT-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int k = 0; k < RD_LAT - 1; k++) begin
          pv[k] <= 1'b0;
          pd[k] <= '0;
        end
      end else begin
        pv[0] <= accept;
        pd[0] <= s0;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          pv[k] <= pv[k-1];
          pd[k] <= pd[k-1];
        end
      end
    assign push_v = pv[RD_LAT-2];
    assign push_d = pd[RD_LAT-2];
  end
  data_mem_rsp_fifo #(.W(RW), .DEPTH(RD_LAT + 1)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(push_v),
    .in_ready(fifo_ready),
    .in_data(push_d),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data(fifo_out)
  );
  assign {rsp_rdata, rsp_err} = fifo_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      fill_q <= '0;
      init_done <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      init_done <= init_done_d;
      out_q <= out_q + OW'(accept) - OW'(pop);
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table vectors, directed corner sequences and random traffic
// against a word-array/queue reference model of data_mem_ctrl.
module tb_data_mem_ctrl;
  import data_mem_pkg::*;
  localparam int DEPTH = 256;
  localparam int RD_LAT = 2;
  typedef struct {
    rsp_t r;
    int cyc;
  } exp_t;
  typedef struct {
    logic we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] exp_rdata;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [14:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, init_done;
  logic [31:0] rsp_rdata;
  logic [31:0] ref_mem [DEPTH];
  exp_t q[$];
  vec_t tbl [12];
  logic [31:0] prev_rdata, got_rdata;
  logic prev_err, got_err, hold_prev = 1'b0, head_seen = 1'b0, lat_exact = 1'b0, last_acc = 1'b0;
  int cyc = 0, n_acc = 0, n_pop = 0, pass_cnt = 0, total = 0;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(15), .RD_LAT(RD_LAT), .INIT_INDEX(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic ref_fill();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
  endtask

  // One clock cycle: sample at the falling edge, score responses, model accepts.
  task automatic cycle();
    logic acc, pop;
    exp_t e;
    int idx;
    @(negedge clk);
    acc = req_valid && req_ready;
    pop = rsp_valid && rsp_ready;
    if (hold_prev) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, prev_rdata);
      chk("hold_err", rsp_err, prev_err);
    end
    if (rsp_valid) begin
      chk("rsp_expected", q.size() != 0, 1);
      if (q.size() != 0 && !head_seen) begin
        head_seen = 1'b1;
        if (lat_exact) chk("lat_exact", cyc - q[0].cyc, RD_LAT);
        else chk("lat_min", (cyc - q[0].cyc) >= RD_LAT, 1);
      end
    end
    if (pop && q.size() != 0) begin
      e = q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.r.rdata);
      chk("rsp_err", rsp_err, e.r.err);
      got_rdata = rsp_rdata;
      got_err = rsp_err;
      n_pop++;
      head_seen = 1'b0;
    end
    hold_prev = rsp_valid && !rsp_ready;
    prev_rdata = rsp_rdata;
    prev_err = rsp_err;
    if (acc) begin
      idx = int'(req_addr >> 2);
      e.cyc = cyc;
      e.r.rdata = '0;
      e.r.err = idx >= DEPTH;
      if (idx < DEPTH && req_we) begin
        for (int k = 0; k < 4; k++)
          if (req_be[k]) ref_mem[idx][8*k +: 8] = req_wdata[8*k +: 8];
      end else if (idx < DEPTH) e.r.rdata = ref_mem[idx];
      q.push_back(e);
      n_acc++;
    end
    last_acc = acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_init_done", init_done, 0);
  endtask

  task automatic wait_init();
    int n, viol, acc0;
    n = 0;
    viol = 0;
    acc0 = n_acc;
    while (!init_done && n < 400) begin
      viol += int'(req_ready);
      cycle();
      n++;
    end
    chk("init_cycles", n, DEPTH + 1);
    chk("init_ready_low", viol, 0);
    chk("init_no_accept", n_acc - acc0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (q.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er);
    int n, p0;
    req_valid = 1'b1;
    req_we = v.we;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_be = v.be;
    n = 0;
    while (n < 10) begin
      cycle();
      n++;
      if (last_acc) break;
    end
    req_valid = 1'b0;
    p0 = n_pop;
    n = 0;
    while (n_pop == p0 && n < 10) begin
      cycle();
      n++;
    end
    chk("rsp_arrived", n_pop != p0, 1);
    rd = got_rdata;
    er = got_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int a0, sp;
    vec_t v;
    tbl[0]  = '{1'b0, 15'h0028, 32'h0,        4'b0000, 32'd10,        1'b0};
    tbl[1]  = '{1'b1, 15'h0010, 32'hAABBCCDD, 4'b0101, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 15'h0010, 32'h0,        4'b0000, 32'h00BB00DD,  1'b0};
    tbl[3]  = '{1'b0, 15'h0400, 32'h0,        4'b0000, 32'h0,         1'b1};
    tbl[4]  = '{1'b0, 15'h03FC, 32'h0,        4'b0000, 32'd255,       1'b0};
    tbl[5]  = '{1'b0, 15'h0013, 32'h0,        4'b0000, 32'h00BB00DD,  1'b0};
    tbl[6]  = '{1'b1, 15'h0400, 32'hFFFFFFFF, 4'b1111, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 15'h03FD, 32'h12345678, 4'b1000, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, 15'h03FC, 32'h0,        4'b0000, 32'h120000FF,  1'b0};
    tbl[9]  = '{1'b0, 15'h7FFC, 32'h0,        4'b0000, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 15'h0000, 32'h0,        4'b0000, 32'h0,         1'b0};
    tbl[11] = '{1'b0, 15'h0401, 32'h0,        4'b0000, 32'h0,         1'b1};
    ref_fill();
    #3;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // A request waiting through INIT must be taken once the fill finishes.
    req_valid = 1'b1;
    req_addr = 15'h0;
    wait_init();
    cycle();
    chk("held_req_accepted", last_acc, 1);
    drain();

    lat_exact = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      do_req(v, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, v.exp_rdata);
      chk($sformatf("tbl%0d_err", i), er, v.exp_err);
    end

    a0 = n_acc;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0030; req_wdata = 32'h11223344; req_be = 4'b1010;
    cycle();
    req_we = 1'b0; req_wdata = '0; req_be = '0;
    cycle();
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc - a0, 2);
    drain();
    chk("b2b_rdata", got_rdata, 32'h1100330C);
    lat_exact = 1'b0;

    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      req_addr = 15'(i * 4);
      cycle();
    end
    req_valid = 1'b0;
    chk("stall_accepts", n_acc - a0, RD_LAT + 1);
    chk("stall_ready_low", req_ready, 0);
    drain();

    for (int i = 0; i < 500; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = $urandom_range(0, 2) != 0;
        req_we = 1'($urandom_range(0, 1));
        req_addr = 15'($urandom_range(0, 'h47F));
        req_wdata = $urandom;
        req_be = 4'($urandom);
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();

    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0008;
    cycle();
    req_addr = 15'h000C;
    cycle();
    req_valid = 1'b0;
    chk("pre_reset_inflight", q.size(), 2);
    chk("pre_reset_rsp_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    hold_prev = 1'b0;
    head_seen = 1'b0;
    ref_fill();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();
    sp = 0;
    repeat (10) begin
      sp += int'(rsp_valid);
      cycle();
    end
    chk("no_stale_rsp", sp, 0);
    v = '{1'b0, 15'h0010, 32'h0, 4'b0000, 32'd4, 1'b0};
    do_req(v, rd, er);
    chk("refill_word4", rd, 32'd4);
    chk("refill_err", er, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_W, default 32: word width in bits, multiple of 8.
- DEPTH, default 256: number of words, power of two.
- ADDR_W, default 15: byte-address width.
- RD_LAT, default 1: request-to-response latency in cycles, range 1..3.
- INIT_INDEX, default 1: 1 = post-reset fill word i with value i; 0 = fill with zero.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid and req_ready are both high.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: write data.
- req_be, in, DATA_W/8: byte-lane write enables.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata, out, DATA_W: read data; 0 for writes and errors.
- rsp_err, out, 1: address out of range.
- init_done, out, 1: fill complete.

Function
REQ-003 Word index SHALL be req_addr >> log2(DATA_W/8); byte-offset bits SHALL be ignored (no misalignment fault).
REQ-004 An index >= DEPTH SHALL set rsp_err=1 and rsp_rdata=0, and SHALL leave memory unmodified.
REQ-005 An accepted write SHALL update only the lanes with req_be[k]=1, at the accepting clock edge.
REQ-006 An accepted read SHALL return the word as it stands after all earlier accepted writes (read-after-write coherent, including a write accepted in the immediately preceding cycle).
REQ-007 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-008 Each response SHALL be presented no earlier than RD_LAT cycles after acceptance; it is presented exactly RD_LAT cycles after acceptance when rsp_ready is held high.
REQ-009 Responses SHALL be staged in a response FIFO of depth RD_LAT+1; an outstanding counter SHALL cover in-flight pipeline entries plus FIFO entries.
REQ-010 req_ready SHALL be 1 only when state=RUN and the outstanding count < RD_LAT+1.
REQ-011 Simultaneous accept and response pop SHALL leave the outstanding count unchanged, allowing one request per cycle sustained.
REQ-012 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err SHALL hold stable.
REQ-013 FSM states SHALL be INIT and RUN.
- INIT: req_ready=0; fill counter walks 0..DEPTH-1, writing one word per cycle (index value, or 0 when INIT_INDEX=0).
- After the final write, the FSM SHALL move to RUN and set init_done=1 in the following cycle.
- RUN: the FSM SHALL stay in RUN until reset.
REQ-014 The fill counter SHALL be log2(DEPTH)+1 bits wide, with no wrap-around before terminal detection.
REQ-015 A request with req_valid=1 during INIT SHALL NOT be accepted and SHALL NOT be dropped; it is held by the requester.

Reset
REQ-016 On rst_n=0, asynchronously: state=INIT, fill counter=0, outstanding=0, FIFO empty, pipeline valids=0.
REQ-017 On rst_n=0, outputs SHALL be req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
REQ-018 Reset mid-operation SHALL discard all in-flight responses and restart INIT; memory contents are rewritten by the fill.
REQ-019 Memory array contents SHALL NOT be cleared by the asynchronous reset itself, only by the INIT fill.

Structure
REQ-020 Package data_mem_pkg SHALL hold the parameter defaults, the state enum {INIT, RUN}, and a response struct {rdata, err}.
REQ-021 Sub-module data_mem_rsp_fifo SHALL implement the parametrised-depth response FIFO with valid/ready on both sides.
REQ-022 The memory array SHALL be a single-write-port synchronous array.

Verification
REQ-023 Reset release -> init_done rises exactly DEPTH+1 cycles later (257 cycles at defaults); req_ready=0 throughout.
REQ-024 After init, read addr 0x0028 -> rsp_rdata=10, rsp_err=0, RD_LAT cycles after accept.
REQ-025 Write addr 0x0010, data 0xAABBCCDD, be=0b0101, then read 0x0010 on the next cycle -> rsp_rdata=0x00BB00DD (original word 4).
REQ-026 Read addr 0x0400 (index 256) -> rsp_err=1, rsp_rdata=0; a following read of index 255 returns 255.
REQ-027 rsp_ready=0 with back-to-back reads -> exactly RD_LAT+1 accepts, then req_ready=0; release rsp_ready -> responses arrive in order with no loss.
REQ-028 Assert rst_n=0 with 2 reads in flight -> rsp_valid=0 immediately; no stale responses appear after the refill completes.
